// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. It produces the
//   write enables and flushes for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline
//   registers and the PC write enable. It resolves data-memory wait states,
//   taken-branch squashes, load-use hazards and mult/div unit occupancy.
//
//   Priority (highest first): memory wait freeze, taken branch, load-use or
//   mult/div stall, normal advance. Outputs are combinational from the inputs
//   and the internal state. While Rst is high every output is 0.
//
// Parameters
//   MD_LAT  cycles the mult/div unit stays busy after an accepted start (>=1)
//   CNT_W   width of the performance counters
//
// Optional feature macro: HAZ_PERF_CNT_EN
//   When defined, adds stall_cnt and flush_cnt performance counters.
//
// Ports
//   Clk, Rst                 clock (rising edge), async active-high reset
//   id_rs, id_rt             source registers of the ID instruction
//   id_use_rs, id_use_rt     ID instruction really reads rs / rt
//   ex_mem_read, ex_rd       EX instruction is a load, and its destination
//   ex_br_taken              branch/jump in EX resolved taken
//   id_md_start, id_md_use   ID instruction is mult/div, or mfhi/mflo
//   mem_req, mem_ready       data-memory access in MEM and its completion
//   pc_we                    PC write enable
//   ifid/idex/exmem/memwb _we, _flush   pipeline register controls
//   md_busy                  mult/div unit still busy
//   stall_cnt, flush_cnt     (HAZ_PERF_CNT_EN only) stall / flush counters
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int MD_LAT = 4,
   parameter int CNT_W  = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd,
   input  logic             ex_br_taken,
   input  logic             id_md_start,
   input  logic             id_md_use,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_flush,
   output logic             exmem_we,
   output logic             exmem_flush,
   output logic             memwb_we,
   output logic             memwb_flush,
`ifdef HAZ_PERF_CNT_EN
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
`endif
   output logic             md_busy
);

   localparam int MD_W = $clog2(MD_LAT + 1);

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [MD_W-1:0] md_cnt;
   logic            mem_wait;
   logic            load_use;
   logic            md_hazard;
   logic            md_accept;

   assign md_busy = (md_cnt != '0);

   assign mem_wait = mem_req & ~mem_ready;

   // Register 0 is hard-wired to zero, so a load targeting it never creates
   // a real dependency.
   assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_use_rs & (id_rs == ex_rd)) |
                      (id_use_rt & (id_rt == ex_rd)));

   assign md_hazard = md_busy & (id_md_start | id_md_use);

   // A start only counts once it really moves into EX: not frozen, not
   // replaced by a bubble and not squashed by a branch.
   assign md_accept = id_md_start & idex_we & ~idex_flush;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of process evaluation order.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output gets a default before the decision tree so no path
   // leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt   = state;
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;
      idex_we     = 1'b0;
      idex_flush  = 1'b0;
      exmem_we    = 1'b0;
      exmem_flush = 1'b0;
      memwb_we    = 1'b0;
      memwb_flush = 1'b0;

      if (Rst) begin
         state_nxt = RUN;
      end else if (mem_wait) begin
         // Data memory stalls: the whole pipeline holds, including the PC.
         state_nxt = MEM_WAIT;
      end else begin
         // Leaving MEM_WAIT happens on the first ready cycle, which already
         // behaves as a normal cycle.
         state_nxt = RUN;
         exmem_we  = 1'b1;
         memwb_we  = 1'b1;
         if (ex_br_taken) begin
            // The ID and IF instructions are on the wrong path; squash both
            // and let the redirected PC load.
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            idex_we    = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use || md_hazard) begin
            // Hold IF and ID, inject a bubble into EX.
            idex_we    = 1'b1;
            idex_flush = 1'b1;
         end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            idex_we = 1'b1;
         end
      end
   end

   // Mult/div occupancy counter. It keeps counting through memory freezes
   // because the unit runs independently of the pipeline registers.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         md_cnt <= '0;
      end else if (md_accept) begin
         md_cnt <= MD_W'(MD_LAT);
      end else if (md_busy) begin
         md_cnt <= md_cnt - MD_W'(1);
      end
   end

`ifdef HAZ_PERF_CNT_EN
   // Counters wrap naturally at 2^CNT_W.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (!pc_we) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (ex_br_taken) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed testbench for pipe_hazard_ctrl. A behavioural model derives the
//   expected outputs from the hazard rules each cycle; the mult/div busy window
//   is tracked as elapsed cycles since the accepted start. Directed steps also
//   carry hand-computed literal expectations.
//   Output vector layout (10 bits, MSB first):
//     pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
//     exmem_we, exmem_flush, memwb_we, memwb_flush, md_busy
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int MD_LAT = 4;
   localparam int CNT_W  = 32;

   // Hand-computed output vectors.
   localparam logic [9:0] V_ZERO   = 10'b0_00_00_00_00_0;
   localparam logic [9:0] V_NORM   = 10'b1_10_10_10_10_0;
   localparam logic [9:0] V_NORM_B = 10'b1_10_10_10_10_1;
   localparam logic [9:0] V_STALL  = 10'b0_00_11_10_10_0;
   localparam logic [9:0] V_STALLB = 10'b0_00_11_10_10_1;
   localparam logic [9:0] V_BRANCH = 10'b1_11_11_10_10_0;
   localparam logic [9:0] V_FRZ_B  = 10'b0_00_00_00_00_1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
   logic       id_use_rs = 0, id_use_rt = 0, ex_mem_read = 0, ex_br_taken = 0;
   logic       id_md_start = 0, id_md_use = 0, mem_req = 0, mem_ready = 1;
   logic       pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
   logic       exmem_we, exmem_flush, memwb_we, memwb_flush, md_busy;
`ifdef HAZ_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
      .Clk         (clk),
      .Rst         (rst),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .ex_mem_read (ex_mem_read),
      .ex_rd       (ex_rd),
      .ex_br_taken (ex_br_taken),
      .id_md_start (id_md_start),
      .id_md_use   (id_md_use),
      .mem_req     (mem_req),
      .mem_ready   (mem_ready),
      .pc_we       (pc_we),
      .ifid_we     (ifid_we),
      .ifid_flush  (ifid_flush),
      .idex_we     (idex_we),
      .idex_flush  (idex_flush),
      .exmem_we    (exmem_we),
      .exmem_flush (exmem_flush),
      .memwb_we    (memwb_we),
      .memwb_flush (memwb_flush),
`ifdef HAZ_PERF_CNT_EN
      .stall_cnt   (stall_cnt),
      .flush_cnt   (flush_cnt),
`endif
      .md_busy     (md_busy)
   );

   function automatic logic [9:0] dut_vec();
      return {pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
              exmem_we, exmem_flush, memwb_we, memwb_flush, md_busy};
   endfunction

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time,
                  got[9:0], exp[9:0]);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit have_start = 0;
   int cyc        = 0;
   int start_cyc  = 0;

   function automatic bit model_busy();
      return have_start && ((cyc - start_cyc) < MD_LAT);
   endfunction

   function automatic logic [9:0] model_vec();
      bit mw, lu, md, busy;
      busy = model_busy();
      if (rst) return V_ZERO;
      mw = mem_req && !mem_ready;
      lu = ex_mem_read && ex_rd != 0 &&
           ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
      md = busy && (id_md_start || id_md_use);
      if (mw)                return {9'b0, busy};
      else if (ex_br_taken)  return {9'b1_11_11_10_10, busy};
      else if (lu || md)     return {9'b0_00_11_10_10, busy};
      else                   return {9'b1_10_10_10_10, busy};
   endfunction

   // Busy window: MD_LAT cycles starting with the cycle after acceptance.
   always @(posedge clk or posedge rst) begin
      logic [9:0] e;
      if (rst) begin
         have_start = 0;
         cyc        = 0;
      end else begin
         e = model_vec();
         if (id_md_start && e[6] && !e[5]) begin
            have_start = 1;
            start_cyc  = cyc + 1;
         end
         cyc = cyc + 1;
      end
   end

   always @(negedge clk) check("model", dut_vec(), model_vec());

   // ---------------- directed stimulus ----------------
   task automatic clear_in();
      id_rs = '0; id_rt = '0; ex_rd = '0;
      id_use_rs = 0; id_use_rt = 0; ex_mem_read = 0; ex_br_taken = 0;
      id_md_start = 0; id_md_use = 0; mem_req = 0; mem_ready = 1;
   endtask

   // Inputs are already driven (posedge+1); check mid-cycle, then advance.
   task automatic step(input string name, input logic [9:0] exp);
      @(negedge clk);
      #1 check(name, dut_vec(), exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 check("reset", dut_vec(), V_ZERO);
`ifdef HAZ_PERF_CNT_EN
      check("rst_stall_cnt", stall_cnt, 0);
      check("rst_flush_cnt", flush_cnt, 0);
`endif
      repeat (2) @(negedge clk);
      #1 rst = 0;
      @(posedge clk);
      #1;

      // No hazard.
      clear_in();
      repeat (3) step("normal", V_NORM);

      // Load-use on rs, one stall cycle then proceed.
      ex_mem_read = 1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1;
      step("lu_rs", V_STALL);
      clear_in();
      step("lu_after", V_NORM);

      // Load-use on rt.
      ex_mem_read = 1; ex_rd = 5'd17; id_rt = 5'd17; id_use_rt = 1;
      step("lu_rt", V_STALL);
      // Matching register but not used: no stall.
      id_use_rt = 0; id_rs = 5'd17; id_use_rs = 0;
      step("lu_unused", V_NORM);
      // ex_rd=0 never stalls.
      ex_rd = 5'd0; id_rs = 5'd0; id_use_rs = 1;
      step("lu_r0", V_NORM);

      // Load-use together with taken branch: branch wins.
      ex_mem_read = 1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1; ex_br_taken = 1;
      step("lu_branch", V_BRANCH);
      clear_in();

      // Mult accepted, then mflo / another mult wait MD_LAT cycles.
      id_md_start = 1;
      step("md_accept", V_NORM);
      id_md_start = 0; id_md_use = 1;
      step("md_stall1", V_STALLB);
      id_md_use = 0; id_md_start = 1;
      step("md_stall2", V_STALLB);
      id_md_start = 0; id_md_use = 1;
      step("md_stall3", V_STALLB);
      step("md_stall4", V_STALLB);
      step("md_proceed", V_NORM);
      clear_in();

      // Memory wait for 3 cycles, load-use also present: freeze wins.
      mem_req = 1; mem_ready = 0;
      ex_mem_read = 1; ex_rd = 5'd3; id_rt = 5'd3; id_use_rt = 1;
      repeat (3) step("mem_freeze", V_ZERO);
      clear_in();
      mem_req = 1; mem_ready = 1;
      step("mem_ready", V_NORM);
      clear_in();

      // Reset while md_cnt=2 and waiting on memory.
      id_md_start = 1;
      step("rst_md_accept", V_NORM);
      id_md_start = 0; mem_req = 1; mem_ready = 0;
      step("rst_frz1", V_FRZ_B);
      step("rst_frz2", V_FRZ_B);
      mem_req = 0; mem_ready = 1;
      #1 check("pre_rst", dut_vec(), V_NORM_B);
      #1 rst = 1;
      #1 check("rst_async", dut_vec(), V_ZERO);
`ifdef HAZ_PERF_CNT_EN
      check("rst_stall_cnt2", stall_cnt, 0);
      check("rst_flush_cnt2", flush_cnt, 0);
`endif
      @(negedge clk);
      #1 rst = 0;
      @(posedge clk);
      #1;
      step("resume", V_NORM);
      id_md_use = 1;
      step("resume_no_md", V_NORM);
      clear_in();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
